// File: rtl/config_cmd_encoder.sv
// Purpose: turns one config command into a framed opcode+payload byte stream for an SPI master TX port.
// Latency: accept to cmd_done = 1 + SETUP + N*(1+stall) + (N-1)*GAP + HOLD cycles; all outputs registered.
// Backpressure: each byte is held on spi_tx_data/spi_tx_valid until spi_tx_ready; new commands are refused while busy.
module config_cmd_encoder #(
  parameter int SETUP_CYCLES = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int HOLD_CYCLES  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [15:0] cmd_data,
  output logic [7:0]  spi_tx_data,
  output logic        spi_tx_valid,
  input  logic        spi_tx_ready,
  output logic        o_CONFIG,
  output logic        busy,
  output logic        cmd_done,
  output logic        err_bad_op
);

  // Counters preload with (cycles - 1) and leave their state on reaching zero.
  localparam logic [7:0] SETUP_LD = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] GAP_LD   = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SEND  = 3'd2,
    S_GAP   = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [1:0]  last_q, last_d;
  logic [7:0]  b0_q, b0_d;
  logic [7:0]  b1_q, b1_d;
  logic [7:0]  b2_q, b2_d;

  logic        cmd_ready_q, cmd_ready_d;
  logic        busy_q, busy_d;
  logic        config_q, config_d;
  logic        valid_q, valid_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, done_d;
  logic        bad_q, bad_d;

  // Byte lane selected by the frame index; index 3 never occurs in a legal frame.
  function automatic logic [7:0] pick_byte(input logic [1:0] i, input logic [7:0] a,
                                           input logic [7:0] b, input logic [7:0] c);
    logic [7:0] r;
    case (i)
      2'd0:    r = a;
      2'd1:    r = b;
      2'd2:    r = c;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Next-state, frame latching and the next value of every registered output.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    last_d  = last_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    b2_d    = b2_q;
    done_d  = 1'b0;
    bad_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          if (cmd_op <= 3'd5) begin
            // Opcode bytes F8..FD follow the op number directly.
            b0_d    = 8'hF8 + {5'd0, cmd_op};
            b1_d    = 8'h00;
            b2_d    = 8'h00;
            last_d  = 2'd0;
            case (cmd_op)
              3'd0, 3'd1: begin
                b1_d   = cmd_data[15:8];
                b2_d   = cmd_data[7:0];
                last_d = 2'd2;
              end
              3'd2: begin
                b1_d   = {6'b0, cmd_data[1:0]};
                last_d = 2'd1;
              end
              3'd3: begin
                b1_d   = cmd_data[7:0];
                last_d = 2'd1;
              end
              default: last_d = 2'd0;
            endcase
            idx_d   = 2'd0;
            cnt_d   = SETUP_LD;
            state_d = S_SETUP;
          end else begin
            bad_d = 1'b1;
          end
        end
      end

      S_SETUP: begin
        if (cnt_q == 8'd0) state_d = S_SEND;
        else               cnt_d   = cnt_q - 8'd1;
      end

      S_SEND: begin
        if (spi_tx_ready) begin
          if (idx_q == last_q) begin
            state_d = S_HOLD;
            cnt_d   = HOLD_LD;
          end else begin
            state_d = S_GAP;
            cnt_d   = GAP_LD;
          end
        end
      end

      S_GAP: begin
        if (cnt_q == 8'd0) begin
          state_d = S_SEND;
          idx_d   = idx_q + 2'd1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      S_HOLD: begin
        if (cnt_q == 8'd0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Outputs follow the state being entered so they change on the same edge as the FSM.
    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    config_d    = (state_d != S_IDLE);
    valid_d     = (state_d == S_SEND);
    data_d      = valid_d ? pick_byte(idx_d, b0_d, b1_d, b2_d) : 8'h00;
  end

  // State, counters and registered outputs; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      idx_q       <= 2'd0;
      last_q      <= 2'd0;
      b0_q        <= 8'h00;
      b1_q        <= 8'h00;
      b2_q        <= 8'h00;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      config_q    <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= 8'h00;
      done_q      <= 1'b0;
      bad_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      b0_q        <= b0_d;
      b1_q        <= b1_d;
      b2_q        <= b2_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      config_q    <= config_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      done_q      <= done_d;
      bad_q       <= bad_d;
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign busy         = busy_q;
  assign o_CONFIG     = config_q;
  assign spi_tx_valid = valid_q;
  assign spi_tx_data  = data_q;
  assign cmd_done     = done_q;
  assign err_bad_op   = bad_q;

endmodule

// File: tb/tb_config_cmd_encoder.sv
// Bench for config_cmd_encoder: table of directed commands, a reset-abort sequence,
// then randomized commands against a byte-stream model plus a small config decoder model.
module tb_config_cmd_encoder;

  localparam int SETUP = 4;
  localparam int GAP   = 2;
  localparam int HOLD  = 4;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    logic [2:0]  op;
    logic [15:0] data;
    int          stall;
    int          n;
    logic [7:0]  b0, b1, b2;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [15:0] cmd_data = 16'd0;
  logic [7:0]  spi_tx_data;
  logic        spi_tx_valid;
  logic        spi_tx_ready = 1'b0;
  logic        o_CONFIG;
  logic        busy;
  logic        cmd_done;
  logic        err_bad_op;

  int checks = 0;
  int failures = 0;

  // Decoder-side view of the registers the frames program.
  logic [15:0] dec_rx = 16'h0;
  logic        dec_flag = 1'b0;
  logic [1:0]  dec_osc = 2'b0;
  logic [7:0]  dec_arthur = 8'h0;

  config_cmd_encoder #(.SETUP_CYCLES(SETUP), .GAP_CYCLES(GAP), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .spi_tx_data(spi_tx_data),
    .spi_tx_valid(spi_tx_valid), .spi_tx_ready(spi_tx_ready), .o_CONFIG(o_CONFIG),
    .busy(busy), .cmd_done(cmd_done), .err_bad_op(err_bad_op)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Protocol model: opcode F8+op, then the payload bytes that op carries.
  function automatic bq_t model(input logic [2:0] op, input logic [15:0] d);
    bq_t q;
    q = {};
    if (op <= 3'd5) begin
      q.push_back(8'hF8 + 8'(op));
      if (op == 3'd0 || op == 3'd1) begin
        q.push_back(d[15:8]);
        q.push_back(d[7:0]);
      end else if (op == 3'd2) begin
        q.push_back(8'(d[1:0]));
      end else if (op == 3'd3) begin
        q.push_back(d[7:0]);
      end
    end
    return q;
  endfunction

  task automatic decode(input bq_t f);
    if (f.size() == 0) return;
    case (f[0])
      8'hF8: if (f.size() >= 3) begin dec_rx = {f[1], f[2]}; dec_flag = 1'b1; end
      8'hFA: if (f.size() >= 2) dec_osc = f[1][1:0];
      8'hFB: if (f.size() >= 2) dec_arthur = f[1];
      8'hFC: dec_flag = 1'b0;
      default: ;
    endcase
  endtask

  // Issue one command, play the SPI master with 'stall' ready-low cycles per byte,
  // and measure framing against the expected byte list.
  task automatic run_cmd(input string nm, input logic [2:0] op, input logic [15:0] d,
                         input int stall, input bq_t exp);
    bq_t got;
    int cyc, setup_n, hold_n, gap_n, gap_bad, stab_bad, ctrl_bad, wait_n, quiet_bad, n;
    logic [7:0] held;
    bit done, prev_valid;
    got = {}; cyc = 0; setup_n = 0; hold_n = 0; gap_n = 0; gap_bad = 0; stab_bad = 0;
    ctrl_bad = 0; wait_n = 0; quiet_bad = 0; done = 0; prev_valid = 0; held = 8'h00;
    n = exp.size();

    @(negedge clk);
    check({nm, " idle_ready"}, int'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d; spi_tx_ready = 1'b0;
    @(negedge clk);
    cyc = 1;
    cmd_data = 16'($urandom);

    if (n == 0) begin
      check({nm, " bad_op_pulse"}, int'({err_bad_op, cmd_ready, o_CONFIG, busy}), 4'b1100);
      cmd_valid = 1'b0;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        spi_tx_ready = 1'($urandom);
        if (err_bad_op || spi_tx_valid || o_CONFIG || busy || !cmd_ready) quiet_bad++;
      end
      check({nm, " bad_op_quiet"}, quiet_bad, 0);
      spi_tx_ready = 1'b0;
      return;
    end

    while (!done && cyc < 3000) begin
      if (cmd_done) begin
        done = 1;
        cmd_valid = 1'b0;
        check({nm, " latency"}, cyc, 1 + SETUP + n * (1 + stall) + (n - 1) * GAP + HOLD);
        check({nm, " done_state"}, int'({o_CONFIG, cmd_ready, busy, spi_tx_valid}), 4'b0100);
      end else begin
        if (cmd_ready || err_bad_op || !busy || !o_CONFIG) ctrl_bad++;
        if (spi_tx_valid) begin
          if (prev_valid && spi_tx_data != held) stab_bad++;
          if (!prev_valid && got.size() > 0 && gap_n != GAP) gap_bad++;
          held = spi_tx_data;
          if (wait_n < stall) begin
            spi_tx_ready = 1'b0; wait_n++; prev_valid = 1;
          end else begin
            spi_tx_ready = 1'b1; got.push_back(spi_tx_data);
            wait_n = 0; prev_valid = 0; gap_n = 0;
          end
        end else begin
          spi_tx_ready = 1'($urandom);
          prev_valid = 0;
          if (got.size() == 0 && o_CONFIG) setup_n++;
          if (got.size() > 0 && got.size() < n) gap_n++;
          if (got.size() >= n && o_CONFIG) hold_n++;
        end
        cmd_valid = 1'($urandom);
        cmd_op = 3'($urandom);
        @(negedge clk);
        cyc++;
      end
    end
    cmd_valid = 1'b0;
    spi_tx_ready = 1'b0;
    if (!done) check({nm, " timeout_no_done"}, 0, 1);

    check({nm, " byte_count"}, got.size(), n);
    for (int i = 0; i < n; i++)
      check($sformatf("%s byte%0d", nm, i), (i < got.size()) ? int'(got[i]) : -1, int'(exp[i]));
    check({nm, " setup_cycles"}, setup_n, SETUP);
    check({nm, " hold_cycles"}, hold_n, HOLD);
    check({nm, " gap_errors"}, gap_bad, 0);
    check({nm, " data_unstable"}, stab_bad, 0);
    check({nm, " ctrl_errors"}, ctrl_bad, 0);
    @(negedge clk);
    check({nm, " done_single_pulse"}, int'({cmd_done, cmd_ready}), 2'b01);
    decode(got);
  endtask

  initial begin
    vec_t tbl[9];
    bq_t exp;
    int hs, quiet_bad;
    bit hit;

    tbl[0] = '{op: 3'd0, data: 16'h1234, stall: 0,  n: 3, b0: 8'hF8, b1: 8'h12, b2: 8'h34};
    tbl[1] = '{op: 3'd2, data: 16'hFFFF, stall: 0,  n: 2, b0: 8'hFA, b1: 8'h03, b2: 8'h00};
    tbl[2] = '{op: 3'd3, data: 16'h00A5, stall: 0,  n: 2, b0: 8'hFB, b1: 8'hA5, b2: 8'h00};
    tbl[3] = '{op: 3'd4, data: 16'hC3C3, stall: 0,  n: 1, b0: 8'hFC, b1: 8'h00, b2: 8'h00};
    tbl[4] = '{op: 3'd5, data: 16'h0F0F, stall: 0,  n: 1, b0: 8'hFD, b1: 8'h00, b2: 8'h00};
    tbl[5] = '{op: 3'd7, data: 16'h1111, stall: 0,  n: 0, b0: 8'h00, b1: 8'h00, b2: 8'h00};
    tbl[6] = '{op: 3'd1, data: 16'hBEEF, stall: 10, n: 3, b0: 8'hF9, b1: 8'hBE, b2: 8'hEF};
    tbl[7] = '{op: 3'd6, data: 16'h2222, stall: 0,  n: 0, b0: 8'h00, b1: 8'h00, b2: 8'h00};
    tbl[8] = '{op: 3'd2, data: 16'h0001, stall: 1,  n: 2, b0: 8'hFA, b1: 8'h01, b2: 8'h00};

    // Reset state while rst is held high.
    repeat (3) @(negedge clk);
    check("reset_ready", int'(cmd_ready), 1);
    check("reset_outputs", int'({spi_tx_valid, o_CONFIG, busy, cmd_done, err_bad_op, spi_tx_data}), 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed table, issued back to back.
    for (int i = 0; i < 9; i++) begin
      exp = {};
      if (tbl[i].n > 0) exp.push_back(tbl[i].b0);
      if (tbl[i].n > 1) exp.push_back(tbl[i].b1);
      if (tbl[i].n > 2) exp.push_back(tbl[i].b2);
      run_cmd($sformatf("vec%0d", i), tbl[i].op, tbl[i].data, tbl[i].stall, exp);
      if (i == 2) begin
        check("dec_rx_value", int'(dec_rx), 16'h1234);
        check("dec_rx_flag_set", int'(dec_flag), 1);
        check("dec_osc", int'(dec_osc), 2'b11);
        check("dec_arthur", int'(dec_arthur), 8'hA5);
      end
      if (i == 3) check("dec_rx_flag_cleared", int'(dec_flag), 0);
    end

    // Reset during the second byte of an EXT_RX frame.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_data = 16'h5A5A;
    @(negedge clk);
    cmd_valid = 1'b0;
    hs = 0; hit = 0;
    for (int k = 0; k < 200 && !hit; k++) begin
      if (spi_tx_valid) begin
        if (hs == 1) begin
          hit = 1;
          rst = 1'b1;
          spi_tx_ready = 1'b0;
        end else begin
          spi_tx_ready = 1'b1;
          hs++;
        end
      end
      if (!hit) @(negedge clk);
    end
    check("rst_abort_reached_byte2", int'(hit), 1);
    @(negedge clk);
    check("rst_abort_ready", int'(cmd_ready), 1);
    check("rst_abort_outputs", int'({spi_tx_valid, o_CONFIG, busy, cmd_done, err_bad_op, spi_tx_data}), 0);
    rst = 1'b0;
    quiet_bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      spi_tx_ready = 1'($urandom);
      if (spi_tx_valid || o_CONFIG || busy) quiet_bad++;
    end
    check("rst_no_resume", quiet_bad, 0);
    spi_tx_ready = 1'b0;
    run_cmd("post_rst", 3'd3, 16'h77C3, 0, model(3'd3, 16'h77C3));

    // Random commands against the model.
    for (int i = 0; i < 24; i++) begin
      logic [2:0]  op;
      logic [15:0] d;
      int          st;
      op = 3'($urandom_range(0, 7));
      d  = 16'($urandom);
      st = $urandom_range(0, 3);
      run_cmd($sformatf("rnd%0d", i), op, d, st, model(op, d));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
